// File: rtl/price_stream_driver_if.sv
// Bundle of the load, stream and result signals between the price stream
// driver (master) and the bench or system that feeds and consumes it (slave).
interface price_stream_driver_if;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [15:0] load_data;
    logic        run;
    logic        busy;
    logic        start_out;
    logic [15:0] price_out;
    logic        new_price_out;
    logic        done_in;
    logic [7:0]  rsi_in;
    logic [7:0]  rsi_q;
    logic        result_valid;
    logic        timeout_err;

    modport master (
        input  load_en, load_addr, load_data, run, done_in, rsi_in,
        output busy, start_out, price_out, new_price_out, rsi_q, result_valid, timeout_err
    );

    modport slave (
        output load_en, load_addr, load_data, run, done_in, rsi_in,
        input  busy, start_out, price_out, new_price_out, rsi_q, result_valid, timeout_err
    );
endinterface

// File: rtl/price_stream_driver.sv
// Upstream initiator for the RSI engine: loads a price table while idle, plays
// it out as paced strobes after a start pulse, then collects the RSI result.
module price_stream_driver #(
    parameter int DEPTH   = 20,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    price_stream_driver_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        EMIT,
        GAP_WAIT,
        WAIT_DONE
    } state_t;

    localparam logic [5:0]  DEPTH_LIM = 6'(DEPTH);
    localparam logic [4:0]  LAST_IDX  = 5'(DEPTH - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_table [DEPTH];
    logic [4:0]  r_idx;
    logic [15:0] r_gapCnt;
    logic [15:0] r_toCnt;
    logic        r_doneDly;
    logic        r_doneSeen;
    logic        r_busy;
    logic        r_start;
    logic [15:0] r_price;
    logic        r_newPrice;
    logic [7:0]  r_rsi;
    logic        r_resultValid;
    logic        r_timeoutErr;

    logic        w_doneRise;
    logic        w_tableWrite;

    assign w_doneRise   = bus.done_in & ~r_doneDly;
    assign w_tableWrite = (r_state == IDLE) && bus.load_en &&
                          ({1'b0, bus.load_addr} < DEPTH_LIM);

    assign bus.busy          = r_busy;
    assign bus.start_out     = r_start;
    assign bus.price_out     = r_price;
    assign bus.new_price_out = r_newPrice;
    assign bus.rsi_q         = r_rsi;
    assign bus.result_valid  = r_resultValid;
    assign bus.timeout_err   = r_timeoutErr;

    // The table has no reset so that a run after reset replays the loaded prices.
    always_ff @(posedge clk) begin
        if (rst_n && w_tableWrite) begin
            r_table[bus.load_addr] <= bus.load_data;
        end
    end

    // Outputs are set on the edge that enters the state in which they are seen,
    // so the strobe is visible in EMIT and the start pulse in START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_gapCnt      <= '0;
            r_toCnt       <= '0;
            r_doneDly     <= 1'b0;
            r_doneSeen    <= 1'b0;
            r_busy        <= 1'b0;
            r_start       <= 1'b0;
            r_price       <= '0;
            r_newPrice    <= 1'b0;
            r_rsi         <= '0;
            r_resultValid <= 1'b0;
            r_timeoutErr  <= 1'b0;
        end else begin
            r_doneDly     <= bus.done_in;
            r_start       <= 1'b0;
            r_newPrice    <= 1'b0;
            r_resultValid <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_doneSeen <= 1'b0;
                    if (bus.run) begin
                        r_start      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_timeoutErr <= 1'b0;
                        r_idx        <= '0;
                        r_gapCnt     <= '0;
                        r_toCnt      <= '0;
                        r_state      <= START;
                    end
                end

                START: begin
                    r_doneSeen <= 1'b0;
                    r_state    <= SETTLE;
                end

                SETTLE: begin
                    if (w_doneRise) begin
                        r_doneSeen <= 1'b1;
                    end
                    r_price    <= r_table[r_idx];
                    r_newPrice <= 1'b1;
                    r_state    <= EMIT;
                end

                EMIT: begin
                    if (w_doneRise) begin
                        r_doneSeen <= 1'b1;
                    end
                    r_gapCnt <= '0;
                    if (r_idx == LAST_IDX) begin
                        r_toCnt <= '0;
                        r_state <= WAIT_DONE;
                    end else begin
                        r_idx   <= r_idx + 5'd1;
                        r_state <= GAP_WAIT;
                    end
                end

                GAP_WAIT: begin
                    if (w_doneRise) begin
                        r_doneSeen <= 1'b1;
                    end
                    if (r_gapCnt == GAP_LAST) begin
                        r_price    <= r_table[r_idx];
                        r_newPrice <= 1'b1;
                        r_state    <= EMIT;
                    end else begin
                        r_gapCnt <= r_gapCnt + 16'd1;
                    end
                end

                // A completion on the same edge as the timeout takes priority.
                WAIT_DONE: begin
                    if (r_doneSeen || w_doneRise) begin
                        r_rsi         <= bus.rsi_in;
                        r_resultValid <= 1'b1;
                        r_busy        <= 1'b0;
                        r_doneSeen    <= 1'b0;
                        r_state       <= IDLE;
                    end else if (r_toCnt == TO_LAST) begin
                        r_timeoutErr <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_toCnt <= r_toCnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_price_stream_driver.sv
// Bench for price_stream_driver: a table of load patterns with expected RSI,
// plus hand-written sequences for timeout, stale done, busy inputs and reset.
module tb_price_stream_driver;

    localparam int DEPTH   = 20;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    price_stream_driver_if bus ();

    price_stream_driver #(
        .DEPTH  (DEPTH),
        .GAP    (GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          pattern;
        logic [15:0] base;
        logic [7:0]  expRsi;
    } vec_t;

    vec_t        vecs [4];
    int          checks        = 0;
    int          failures      = 0;
    int          cyc           = 0;
    int          startCyc      = 0;
    int          startCount    = 0;
    int          strobeIdx     = 0;
    int          totalStrobes  = 0;
    int          lastStrobeCyc = 0;
    int          resultCount   = 0;
    int          resultCyc     = 0;
    int          terrRiseCyc   = 0;
    int          gainSum       = 0;
    int          lossSum       = 0;
    logic        havePrev      = 1'b0;
    logic        prevStart     = 1'b0;
    logic        prevRv        = 1'b0;
    logic        prevTerr      = 1'b0;
    logic [15:0] prevPrice     = '0;
    logic [15:0] lastPrice     = '0;
    logic [15:0] tbTable [DEPTH];
    logic [15:0] expPrice [$];
    logic [7:0]  expRsi [$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] rsiOf(input int g, input int l);
        if (g + l == 0) return 8'd0;
        return 8'((g * 100) / (g + l));
    endfunction

    function automatic logic [15:0] patternValue(input int pattern, input logic [15:0] base, input int i);
        case (pattern)
            0:       return base + 16'(i);
            1:       return (i % 2 == 1) ? base + 16'd10 : base;
            2:       return base;
            default: return base + 16'((i % 4) * 10);
        endcase
    endfunction

    function automatic logic [7:0] computeRsi();
        int g = 0;
        int l = 0;
        for (int i = 1; i < DEPTH; i++) begin
            if (tbTable[i] > tbTable[i-1]) g += int'(tbTable[i]) - int'(tbTable[i-1]);
            else l += int'(tbTable[i-1]) - int'(tbTable[i]);
        end
        return rsiOf(g, l);
    endfunction

    // Consumer model and scoreboard: checks every strobe against the queued
    // prices and timing, and feeds rsi_in from the prices it actually received.
    always @(negedge clk) begin
        cyc++;
        if (cyc == 1) bus.rsi_in = 8'd0;
        if (bus.start_out) begin
            checkOutput("startPulseWidth", int'(prevStart), 0);
            startCount++;
            startCyc  = cyc;
            strobeIdx = 0;
            gainSum   = 0;
            lossSum   = 0;
            havePrev  = 1'b0;
            bus.rsi_in = 8'd0;
        end
        if (bus.new_price_out) begin
            if (expPrice.size() == 0) checkOutput("strobeUnexpected", 1, 0);
            else checkOutput("strobePrice", int'(bus.price_out), int'(expPrice.pop_front()));
            checkOutput("strobeTime", cyc - startCyc, 2 + strobeIdx * (GAP + 1));
            if (havePrev) begin
                if (bus.price_out > prevPrice) gainSum += int'(bus.price_out) - int'(prevPrice);
                else lossSum += int'(prevPrice) - int'(bus.price_out);
            end
            prevPrice     = bus.price_out;
            lastPrice     = bus.price_out;
            havePrev      = 1'b1;
            strobeIdx++;
            totalStrobes++;
            lastStrobeCyc = cyc;
            bus.rsi_in    = rsiOf(gainSum, lossSum);
        end else if (bus.busy && strobeIdx > 0) begin
            checkOutput("priceHold", int'(bus.price_out), int'(lastPrice));
        end
        if (bus.result_valid) begin
            checkOutput("resultPulseWidth", int'(prevRv), 0);
            if (expRsi.size() == 0) checkOutput("resultUnexpected", 1, 0);
            else checkOutput("rsiQ", int'(bus.rsi_q), int'(expRsi.pop_front()));
            resultCount++;
            resultCyc = cyc;
        end
        if (bus.timeout_err && !prevTerr) terrRiseCyc = cyc;
        prevStart = bus.start_out;
        prevRv    = bus.result_valid;
        prevTerr  = bus.timeout_err;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_start"}, int'(bus.start_out), 0);
        checkOutput({tag, "_newPrice"}, int'(bus.new_price_out), 0);
        checkOutput({tag, "_resultValid"}, int'(bus.result_valid), 0);
        checkOutput({tag, "_timeoutErr"}, int'(bus.timeout_err), 0);
        checkOutput({tag, "_price"}, int'(bus.price_out), 0);
        checkOutput({tag, "_rsiQ"}, int'(bus.rsi_q), 0);
    endtask

    // Writes entries 1..DEPTH-1 and leaves entry 0 on the bus so that it is
    // written on the same edge that accepts the run.
    task automatic loadTable(input int pattern, input logic [15:0] base);
        for (int i = 0; i < DEPTH; i++) tbTable[i] = patternValue(pattern, base, i);
        for (int i = 1; i < DEPTH; i++) begin
            bus.load_en   = 1'b1;
            bus.load_addr = 5'(i);
            bus.load_data = tbTable[i];
            tick();
        end
        bus.load_addr = 5'd0;
        bus.load_data = tbTable[0];
    endtask

    task automatic applyStimulus(input bit pushRsi, input logic [7:0] rsiExp);
        for (int i = 0; i < DEPTH; i++) expPrice.push_back(tbTable[i]);
        if (pushRsi) expRsi.push_back(rsiExp);
        bus.run = 1'b1;
        tick();
        bus.run     = 1'b0;
        bus.load_en = 1'b0;
    endtask

    task automatic waitStrobes(input int target, input int budget, input string name);
        int n = 0;
        while (totalStrobes < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, int'(totalStrobes >= target), 1);
    endtask

    task automatic waitResult(input int target, input int budget, input string name);
        int n = 0;
        while (resultCount < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, int'(resultCount >= target), 1);
    endtask

    task automatic pulseDone();
        bus.done_in = 1'b1;
        tick();
        bus.done_in = 1'b0;
    endtask

    task automatic finishRun(input int sBase, input int rBase, input string tag);
        waitStrobes(sBase + DEPTH, 200, {tag, "_streamDone"});
        pulseDone();
        waitResult(rBase + 1, 20, {tag, "_resultSeen"});
        tick();
        checkOutput({tag, "_strobeCount"}, totalStrobes - sBase, DEPTH);
        checkOutput({tag, "_busyAfter"}, int'(bus.busy), 0);
        checkOutput({tag, "_timeoutErr"}, int'(bus.timeout_err), 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sBase;
        int rBase;
        int sc;
        int n;

        vecs[0] = '{0, 16'd100, 8'd100};
        vecs[1] = '{1, 16'd100, 8'd52};
        vecs[2] = '{2, 16'd500, 8'd0};
        vecs[3] = '{3, 16'd1000, 8'd55};

        bus.load_en   = 1'b0;
        bus.load_addr = 5'd0;
        bus.load_data = 16'd0;
        bus.run       = 1'b0;
        bus.done_in   = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            sBase = totalStrobes;
            rBase = resultCount;
            loadTable(vecs[v].pattern, vecs[v].base);
            applyStimulus(1'b1, vecs[v].expRsi);
            finishRun(sBase, rBase, $sformatf("vec%0d", v));
        end

        $display("[TB] done rise during stream is latched");
        sBase = totalStrobes;
        rBase = resultCount;
        loadTable(0, 16'd100);
        applyStimulus(1'b1, computeRsi());
        waitStrobes(sBase + 5, 100, "latch_midStream");
        pulseDone();
        waitStrobes(sBase + DEPTH, 200, "latch_streamDone");
        waitResult(rBase + 1, 20, "latch_resultSeen");
        checkOutput("latch_latency", resultCyc - lastStrobeCyc, 2);

        $display("[TB] timeout with done held low");
        tick();
        sBase = totalStrobes;
        rBase = resultCount;
        applyStimulus(1'b0, 8'd0);
        waitStrobes(sBase + DEPTH, 200, "to_streamDone");
        n = 0;
        while (!bus.timeout_err && n < 60) begin
            tick();
            n++;
        end
        checkOutput("to_seen", int'(bus.timeout_err), 1);
        tick();
        checkOutput("to_latency", terrRiseCyc - lastStrobeCyc, TIMEOUT + 1);
        checkOutput("to_busy", int'(bus.busy), 0);
        checkOutput("to_rsiHeld", int'(bus.rsi_q), 100);
        checkOutput("to_noResult", resultCount, rBase);
        checkOutput("to_sticky", int'(bus.timeout_err), 1);
        sBase = totalStrobes;
        loadTable(1, 16'd100);
        applyStimulus(1'b1, computeRsi());
        checkOutput("to_clearedOnRun", int'(bus.timeout_err), 0);
        finishRun(sBase, rBase, "to_rerun");

        $display("[TB] stale done held across run start");
        bus.done_in = 1'b1;
        repeat (2) tick();
        sBase = totalStrobes;
        rBase = resultCount;
        loadTable(2, 16'd500);
        applyStimulus(1'b1, computeRsi());
        repeat (3) tick();
        bus.done_in = 1'b0;
        waitStrobes(sBase + DEPTH, 200, "stale_streamDone");
        tick();
        checkOutput("stale_ignored", resultCount, rBase);
        checkOutput("stale_busy", int'(bus.busy), 1);
        pulseDone();
        waitResult(rBase + 1, 20, "stale_resultSeen");
        tick();
        checkOutput("stale_resultCount", resultCount, rBase + 1);

        $display("[TB] run and load while busy");
        sBase = totalStrobes;
        rBase = resultCount;
        loadTable(0, 16'd100);
        applyStimulus(1'b1, computeRsi());
        waitStrobes(sBase + 5, 100, "busy_midStream");
        sc = startCount;
        bus.run       = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 5'd3;
        bus.load_data = 16'd999;
        tick();
        bus.run     = 1'b0;
        bus.load_en = 1'b0;
        finishRun(sBase, rBase, "busy_run");
        checkOutput("busy_noRestart", startCount, sc);
        bus.load_en   = 1'b1;
        bus.load_addr = 5'd20;
        bus.load_data = 16'd4444;
        tick();
        bus.load_en = 1'b0;
        sBase = totalStrobes;
        rBase = resultCount;
        applyStimulus(1'b1, computeRsi());
        finishRun(sBase, rBase, "busy_replay");

        $display("[TB] reset mid-stream");
        sBase = totalStrobes;
        applyStimulus(1'b1, computeRsi());
        waitStrobes(sBase + 7, 100, "rst_seventh");
        rst_n = 1'b0;
        tick();
        checkAllZero("midReset");
        rst_n = 1'b1;
        expPrice.delete();
        expRsi.delete();
        sBase = totalStrobes;
        repeat (8) tick();
        checkOutput("rst_noStrobes", totalStrobes, sBase);
        rBase = resultCount;
        applyStimulus(1'b1, computeRsi());
        finishRun(sBase, rBase, "rst_replay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/price_stream_driver.md
Name: price_stream_driver

Overview:
Upstream initiator for the RSI engine. It holds a DEPTH-entry price table that is loaded while idle. On `run` it issues a one-cycle `start`, then plays the table out as paced `price` / `new_price` strobes. It then waits for the engine's `done`, captures the returned RSI byte and reports `result_valid` or a timeout.

Parameters:
DEPTH, 20, number of table entries streamed per run (2..32); must equal the consumer's window depth
GAP, 2, idle cycles between consecutive new_price strobes (>=1)
TIMEOUT, 1024, max cycles spent in WAIT_DONE before abort (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; synchronous, active-low
load_en  in  1  table write strobe, honoured only in IDLE
load_addr  in  5  table index, 0..DEPTH-1; writes to out-of-range addresses are dropped
load_data  in  16  price written to table[load_addr]
run  in  1  begin a streaming run, honoured only in IDLE
busy  out  1  high in every state except IDLE
start_out  out  1  one-cycle start pulse to the consumer
price_out  out  16  current streamed price
new_price_out  out  1  one-cycle strobe qualifying price_out
done_in  in  1  consumer completion level
rsi_in  in  8  consumer RSI result
rsi_q  out  8  captured RSI, held until the next capture
result_valid  out  1  one-cycle pulse when rsi_q updates
timeout_err  out  1  sticky; set on timeout, cleared when the next run is accepted

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - busy, start_out, new_price_out, result_valid and timeout_err go to 0.
  - price_out and rsi_q go to 0.
  - Index, gap and timeout counters clear.
  - Table contents are not cleared.
  - Reset mid-run aborts immediately; no further strobes are issued.
- All outputs are registered.
- States: IDLE, START, SETTLE, EMIT, GAP_WAIT, WAIT_DONE.
- IDLE:
  - load_en writes the table the same edge.
  - When run=1: start_out <= 1, busy <= 1, timeout_err <= 0, idx <= 0, go to START.
  - If load_en and run are both high on the same edge, the write happens and the run starts.
  - A write to the entry at idx 0 lands before it is read.
- START: start_out <= 0, go to SETTLE. This gives the consumer one cycle to leave its idle state.
- SETTLE: go to EMIT. The first new_price_out is therefore high exactly 2 cycles after the start_out cycle.
- EMIT:
  - price_out <= table[idx], new_price_out <= 1 for one cycle.
  - If idx == DEPTH-1, go to WAIT_DONE; otherwise idx <= idx+1 and go to GAP_WAIT.
- GAP_WAIT:
  - new_price_out low for GAP cycles, then go to EMIT.
  - Strobe period is GAP+1 cycles.
- price_out holds its value from its strobe cycle until the next EMIT, and after the final strobe until the next run. This keeps data stable for a consumer that registers its write enable one cycle late.
- done_in handling:
  - A rising-edge detector on done_in is armed from SETTLE onward and ignored in IDLE/START. A stale high done from the previous run is therefore not a completion.
  - A rise seen before WAIT_DONE is latched and serviced on entry to WAIT_DONE.
- WAIT_DONE:
  - A 16-bit timeout counter increments each cycle.
  - On a latched or current done_in rise: rsi_q <= rsi_in, result_valid <= 1 for one cycle, busy <= 0, go to IDLE.
  - If the counter reaches TIMEOUT first: timeout_err <= 1, busy <= 0, go to IDLE; rsi_q is unchanged and no result_valid.
  - If done and timeout coincide, done wins.
- load_en and run while busy are ignored; no queuing.
- Total cycles from the start_out pulse to the last strobe: 2 + (DEPTH-1)·(GAP+1).

Test Plan:
1. Ramp load: table[i]=100+i, DEPTH=20, GAP=2, run.
   - start_out is high 1 cycle.
   - Strobes land at start+2, +5, …, +59, with price_out = 100..119 in order.
   - Exactly 20 strobes.
2. End-to-end with the RSI engine, table alternating 100,110,100,…,110:
   - After done, rsi_q=52 and result_valid is high for exactly 1 cycle.
   - Ramp from test 1 → 100; constant table of 500 → 0.
3. Timeout: TIMEOUT=16, done_in tied 0.
   - timeout_err rises exactly 16 cycles after WAIT_DONE entry.
   - busy falls, rsi_q is unchanged, no result_valid.
   - A second run clears timeout_err.
4. Stale done: hold done_in=1 from before run until 3 cycles after start_out, then drop it, then pulse it in WAIT_DONE.
   - Only the later rise produces result_valid.
5. Run or load while busy: assert run mid-stream and load_en at addr 3 with data 999.
   - Stream is unaffected, no second start_out.
   - table[3] still holds its prior value on the next run.
6. Reset mid-stream: pull rst_n low after the 7th strobe.
   - The next edge shows all outputs 0 and state IDLE.
   - A subsequent run replays the unchanged table from index 0.
